// File: rtl/axi_ro_arbiter.sv
// Two-requester arbiter for a shared AXI4-Lite read channel (AR + R).
// One transaction in flight; the grant is held from arbitration until the R handshake completes.
module axi_ro_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   sel_arvalid;
  logic   sel_rready;

  assign sel_arvalid = grant_q ? s1_arvalid : s0_arvalid;
  assign sel_rready  = grant_q ? s1_rready  : s0_rready;

  // Address always follows the registered grant so the mux never switches mid-phase.
  assign m_araddr = grant_q ? s1_araddr : s0_araddr;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_arvalid && s1_arvalid) begin
          grant_d = ROUND_ROBIN ? ~last_q : 1'b0;
          state_d = ADDR;
        end else if (s0_arvalid) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (s1_arvalid) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid  = sel_arvalid;
        s0_arready = !grant_q && m_arready;
        s1_arready = grant_q && m_arready;
        // A withdrawn request abandons the grant without touching the fairness history.
        if (!sel_arvalid) begin
          state_d = IDLE;
        end else if (m_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_rready  = sel_rready;
        s0_rvalid = !grant_q && m_rvalid;
        s1_rvalid = grant_q && m_rvalid;
        if (m_rvalid && sel_rready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_ro_arbiter.sv
// Randomized bench for axi_ro_arbiter with a transaction-level reference model,
// plus directed reset, fairness and fixed-priority sequences.
module tb_axi_ro_arbiter;

  localparam bit RR = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr [2];
  logic        arvalid [2];
  logic        rready [2];
  logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid;
  logic [31:0] s0_rdata, s1_rdata;
  logic [31:0] m_araddr, m_rdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, grant, busy;

  logic        fp_rst;
  logic [31:0] fp_s0_araddr, fp_s1_araddr, fp_s0_rdata, fp_s1_rdata, fp_m_araddr, fp_m_rdata;
  logic        fp_s0_arvalid, fp_s1_arvalid, fp_s0_arready, fp_s1_arready;
  logic        fp_s0_rvalid, fp_s1_rvalid, fp_s0_rready, fp_s1_rready;
  logic        fp_m_arvalid, fp_m_arready, fp_m_rvalid, fp_m_rready, fp_grant, fp_busy;

  always #5 clk = ~clk;

  axi_ro_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(RR)) u_dut (
    .clk(clk), .rst(rst),
    .s0_araddr(araddr[0]), .s0_arvalid(arvalid[0]), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid), .s0_rready(rready[0]),
    .s1_araddr(araddr[1]), .s1_arvalid(arvalid[1]), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid), .s1_rready(rready[1]),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  axi_ro_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .rst(fp_rst),
    .s0_araddr(fp_s0_araddr), .s0_arvalid(fp_s0_arvalid), .s0_arready(fp_s0_arready),
    .s0_rdata(fp_s0_rdata), .s0_rvalid(fp_s0_rvalid), .s0_rready(fp_s0_rready),
    .s1_araddr(fp_s1_araddr), .s1_arvalid(fp_s1_arvalid), .s1_arready(fp_s1_arready),
    .s1_rdata(fp_s1_rdata), .s1_rvalid(fp_s1_rvalid), .s1_rready(fp_s1_rready),
    .m_araddr(fp_m_araddr), .m_arvalid(fp_m_arvalid), .m_arready(fp_m_arready),
    .m_rdata(fp_m_rdata), .m_rvalid(fp_m_rvalid), .m_rready(fp_m_rready),
    .grant(fp_grant), .busy(fp_busy)
  );

  int          n_tests, n_fail;
  // reference model: owner = -1 when no grant is held
  int          owner, last_win, gnt;
  bit          addr_done;
  int          rq_st [2];       // 0 idle, 1 requesting, 2 awaiting data
  logic [31:0] rq_a [2];
  bit          mem_have;
  logic [31:0] mem_addr;
  bit          greedy, hold_rv;
  int          ar_log [$];
  logic [31:0] addr_log [$];

  function automatic logic [31:0] md(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; addr_done = 0; last_win = 1; gnt = 0; mem_have = 0;
    rq_st[0] = 0; rq_st[1] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin arvalid[i] = 1'b0; rready[i] = 1'b0; end
    m_arready = 1'b0; m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    check_eq("rst_m_rready", 32'(m_rready), 32'd0);
    check_eq("rst_s_ready_valid", 32'({s0_arready, s1_arready, s0_rvalid, s1_rvalid}), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    int          n_owner, n_last, n_gnt;
    bit          n_done;
    logic        e_marv, e_mrr;
    logic        e_arr [2], e_rv [2], arr [2], rv [2];
    logic [31:0] rd [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rq_st[i] == 0 && (greedy || $urandom_range(0, 9) < 4)) begin
        rq_st[i] = 1;
        rq_a[i]  = $urandom() & 32'hFFFF_FFFC;
      end
      araddr[i]  = rq_a[i];
      arvalid[i] = (rq_st[i] == 1) && (greedy || $urandom_range(0, 49) != 0);
      rready[i]  = greedy || ($urandom_range(0, 9) < 7);
    end
    m_arready = greedy || ($urandom_range(0, 9) < 6);
    if (mem_have) begin
      m_rvalid = greedy || ($urandom_range(0, 9) < 6);
      m_rdata  = md(mem_addr);
    end else begin
      m_rvalid = ($urandom_range(0, 9) < 3);
      m_rdata  = $urandom();
    end
    if (hold_rv) m_rvalid = 1'b0;
    #1;
    arr[0] = s0_arready; arr[1] = s1_arready;
    rv[0]  = s0_rvalid;  rv[1]  = s1_rvalid;
    rd[0]  = s0_rdata;   rd[1]  = s1_rdata;
    e_marv = 1'b0; e_mrr = 1'b0;
    for (int i = 0; i < 2; i++) begin e_arr[i] = 1'b0; e_rv[i] = 1'b0; end
    if (owner >= 0 && !addr_done) begin
      e_marv = arvalid[owner];
      e_arr[owner] = m_arready;
    end
    if (owner >= 0 && addr_done) begin
      e_mrr = rready[owner];
      e_rv[owner] = m_rvalid;
    end
    check_eq("busy", 32'(busy), 32'(owner >= 0));
    check_eq("grant", 32'(grant), gnt);
    check_eq("m_araddr", m_araddr, araddr[gnt]);
    check_eq("m_arvalid", 32'(m_arvalid), 32'(e_marv));
    check_eq("m_rready", 32'(m_rready), 32'(e_mrr));
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("s%0d_arready", i), 32'(arr[i]), 32'(e_arr[i]));
      check_eq($sformatf("s%0d_rvalid", i), 32'(rv[i]), 32'(e_rv[i]));
      check_eq($sformatf("s%0d_rdata", i), rd[i], m_rdata);
      if (e_rv[i] && rready[i]) check_eq($sformatf("s%0d_rx_data", i), rd[i], md(rq_a[i]));
    end
    n_owner = owner; n_done = addr_done; n_last = last_win; n_gnt = gnt;
    if (owner < 0) begin
      if (arvalid[0] && arvalid[1]) n_owner = RR ? 1 - last_win : 0;
      else if (arvalid[0]) n_owner = 0;
      else if (arvalid[1]) n_owner = 1;
      if (n_owner >= 0) begin n_gnt = n_owner; n_done = 0; end
    end else if (!addr_done) begin
      if (!arvalid[owner]) n_owner = -1;
      else if (m_arready) begin
        n_done = 1;
        ar_log.push_back(owner);
        addr_log.push_back(araddr[owner]);
        mem_have = 1; mem_addr = araddr[owner]; rq_st[owner] = 2;
      end
    end else if (m_rvalid && rready[owner]) begin
      n_last = owner; n_owner = -1;
      mem_have = 0; rq_st[owner] = 0;
    end
    owner = n_owner; addr_done = n_done; last_win = n_last; gnt = n_gnt;
  endtask

  initial begin
    int cnt0, s1_act;
    bit found;
    n_tests = 0; n_fail = 0; greedy = 0; hold_rv = 0;
    rst = 1'b1; fp_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin araddr[i] = '0; rq_a[i] = '0; end
    m_rdata = '0;
    fp_s0_araddr = 32'h40; fp_s1_araddr = 32'h80;
    fp_s0_arvalid = 1'b1; fp_s1_arvalid = 1'b1; fp_s0_rready = 1'b1; fp_s1_rready = 1'b1;
    fp_m_arready = 1'b1; fp_m_rvalid = 1'b1; fp_m_rdata = 32'hCAFE_F00D;

    do_reset();
    rq_st[0] = 1; rq_a[0] = 32'h10; rq_st[1] = 1; rq_a[1] = 32'h20;
    repeat (800) cycle();

    // park in DATA with no response pending, then reset asynchronously
    hold_rv = 1; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      cycle();
      if (owner >= 0 && addr_done) found = 1;
    end
    check_eq("mid_rst_reach_data", 32'(found), 32'd1);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    check_eq("mid_rst_busy_before", 32'(busy), 32'(found));
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_m_arvalid", 32'(m_arvalid), 32'd0);
    check_eq("mid_rst_m_rready", 32'(m_rready), 32'd0);
    check_eq("mid_rst_rvalid", 32'({s0_rvalid, s1_rvalid}), 32'd0);
    hold_rv = 0;
    do_reset();

    // tie from reset, then both requesters stay hungry
    rq_st[0] = 1; rq_a[0] = 32'h10; rq_st[1] = 1; rq_a[1] = 32'h20;
    greedy = 1; ar_log.delete(); addr_log.delete();
    repeat (25) cycle();
    check_eq("rr_count", 32'(ar_log.size() >= 6), 32'd1);
    if (ar_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) check_eq($sformatf("rr_seq%0d", k), ar_log[k], k % 2);
      check_eq("tie_addr0", addr_log[0], 32'h10);
      check_eq("tie_addr1", addr_log[1], 32'h20);
    end
    greedy = 0;
    repeat (400) cycle();

    // fixed-priority instance: s1 must starve
    cnt0 = 0; s1_act = 0;
    @(negedge clk);
    fp_rst = 1'b0;
    repeat (18) begin
      @(posedge clk);
      #1;
      if (fp_s0_rvalid) cnt0++;
      if (fp_s1_arready || fp_s1_rvalid) s1_act++;
      check_eq("fp_grant", 32'(fp_grant), 32'd0);
      check_eq("fp_m_araddr", fp_m_araddr, fp_s0_araddr);
      check_eq("fp_arvalid_arready", 32'(fp_m_arvalid), 32'(fp_s0_arready));
      check_eq("fp_rready", 32'(fp_m_rready), 32'(fp_s0_rvalid));
      check_eq("fp_busy", 32'(fp_busy), 32'(fp_m_arvalid | fp_m_rready));
      check_eq("fp_rdata", fp_s0_rdata ^ fp_s1_rdata, 32'd0);
    end
    check_eq("fp_s0_grants", cnt0, 6);
    check_eq("fp_s1_activity", s1_act, 0);
    check_eq("fp_rdata_value", fp_s1_rdata, fp_m_rdata);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
